lsb_queue: RTL and testbench

- Parametrised in-order load/store buffer for the out-of-order core; successor of the fixed 8-entry LSB.
- Sits between decoder/dispatch, the ROB, the CDB and the data cache.
- Adds over the fixed 8-entry LSB:
  - configurable depth, ROB tag width and CDB snoop-port count;
  - a registered result broadcast;
  - safe discard of an in-flight load across a ROB flush.

---
 rtl/lsb_queue_pkg.sv | 20 ++
 rtl/lsb_queue_if.sv | 52 +++++
 rtl/lsb_queue_cdb_match.sv | 43 ++++
 rtl/lsb_queue.sv | 206 ++++++++++++++++++++
 tb/tb_lsb_queue.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsb_queue_pkg.sv
// Shared encodings for the load/store queue: entry states, inst_type layout,
// funct3 codes and the default I/O region position.
package lsb_queue_pkg;

   typedef enum logic {
      ST_WAIT   = 1'b0,
      ST_ISSUED = 1'b1
   } ent_state_e;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned STORE_BIT = 3;
   localparam int unsigned IO_HI_DEF = 17;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsb_queue_if.sv
// Dispatch, ROB, CDB and data-cache signals of the load/store queue.
interface lsb_queue_if #(
   parameter int unsigned ROB_W = 4,
   parameter int unsigned CDB_N = 2
);
   import lsb_queue_pkg::*;

   logic                      rob_clear;
   logic [ROB_W-1:0]          rob_head_id;
   logic                      lsb_full;
   logic                      inst_valid;
   logic [3:0]                inst_type;
   logic [DATA_W-1:0]         inst_r1_val;
   logic [DATA_W-1:0]         inst_r2_val;
   logic                      inst_r1_dep_v;
   logic                      inst_r2_dep_v;
   logic [ROB_W-1:0]          inst_r1_dep;
   logic [ROB_W-1:0]          inst_r2_dep;
   logic [DATA_W-1:0]         inst_imm;
   logic [ROB_W-1:0]          inst_rob_id;
   logic [CDB_N-1:0]          cdb_valid;
   logic [CDB_N*ROB_W-1:0]    cdb_rob_id;
   logic [CDB_N*DATA_W-1:0]   cdb_value;
   logic                      lsb_fi;
   logic [ROB_W-1:0]          lsb_rob_id;
   logic [DATA_W-1:0]         lsb_value;
   logic                      mem_req;
   logic                      mem_write;
   logic [DATA_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [2:0]                mem_type;
   logic                      mem_handle;
   logic                      mem_ready;
   logic [DATA_W-1:0]         mem_rdata;

   modport slave (
      input  rob_clear, rob_head_id, inst_valid, inst_type, inst_r1_val, inst_r2_val,
             inst_r1_dep_v, inst_r2_dep_v, inst_r1_dep, inst_r2_dep, inst_imm, inst_rob_id,
             cdb_valid, cdb_rob_id, cdb_value, mem_handle, mem_ready, mem_rdata,
      output lsb_full, lsb_fi, lsb_rob_id, lsb_value,
             mem_req, mem_write, mem_addr, mem_wdata, mem_type
   );

   modport master (
      output rob_clear, rob_head_id, inst_valid, inst_type, inst_r1_val, inst_r2_val,
             inst_r1_dep_v, inst_r2_dep_v, inst_r1_dep, inst_r2_dep, inst_imm, inst_rob_id,
             cdb_valid, cdb_rob_id, cdb_value, mem_handle, mem_ready, mem_rdata,
      input  lsb_full, lsb_fi, lsb_rob_id, lsb_value,
             mem_req, mem_write, mem_addr, mem_wdata, mem_type
   );

endinterface

// File: rtl/lsb_queue_cdb_match.sv
// Resolves one pending operand against the CDB ports and the queue's own
// broadcast; lowest CDB port wins, own broadcast is checked last.
module lsb_cdb_match
   import lsb_queue_pkg::*;
#(
   parameter int unsigned ROB_W = 4,
   parameter int unsigned CDB_N = 2
) (
   input  logic                    pend_i,
   input  logic [ROB_W-1:0]        dep_i,
   input  logic [DATA_W-1:0]       val_i,
   input  logic [CDB_N-1:0]        cdb_valid_i,
   input  logic [CDB_N*ROB_W-1:0]  cdb_rob_id_i,
   input  logic [CDB_N*DATA_W-1:0] cdb_value_i,
   input  logic                    fi_i,
   input  logic [ROB_W-1:0]        fi_rob_i,
   input  logic [DATA_W-1:0]       fi_val_i,
   output logic                    pend_o,
   output logic [DATA_W-1:0]       val_o
);

   logic hit;

   always_comb begin
      hit    = 1'b0;
      pend_o = pend_i;
      val_o  = val_i;
      if (pend_i) begin
         for (int k = 0; k < CDB_N; k++) begin
            if (!hit && cdb_valid_i[k] && (cdb_rob_id_i[k*ROB_W +: ROB_W] == dep_i)) begin
               hit   = 1'b1;
               val_o = cdb_value_i[k*DATA_W +: DATA_W];
            end
         end
         if (!hit && fi_i && (fi_rob_i == dep_i)) begin
            hit   = 1'b1;
            val_o = fi_val_i;
         end
         pend_o = !hit;
      end
   end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store queue: circular buffer of memory ops with CDB snooping,
// head-only cache issue and a registered one-cycle result broadcast.
module lsb_queue
   import lsb_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned ROB_W = 4,
   parameter int unsigned CDB_N = 2,
   parameter int unsigned IO_HI = IO_HI_DEF
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       rdy_in,
   lsb_queue_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              drop_q, drop_d;
   logic              fi_q, fi_d;
   logic [ROB_W-1:0]  fi_rob_q, fi_rob_d;
   logic [DATA_W-1:0] fi_val_q, fi_val_d;

   logic              ent_v_q     [DEPTH], ent_v_d     [DEPTH];
   ent_state_e        ent_st_q    [DEPTH], ent_st_d    [DEPTH];
   logic              ent_store_q [DEPTH], ent_store_d [DEPTH];
   logic [2:0]        ent_f3_q    [DEPTH], ent_f3_d    [DEPTH];
   logic              ent_r1p_q   [DEPTH], ent_r1p_d   [DEPTH];
   logic              ent_r2p_q   [DEPTH], ent_r2p_d   [DEPTH];
   logic [ROB_W-1:0]  ent_d1_q    [DEPTH], ent_d1_d    [DEPTH];
   logic [ROB_W-1:0]  ent_d2_q    [DEPTH], ent_d2_d    [DEPTH];
   logic [DATA_W-1:0] ent_r1_q    [DEPTH], ent_r1_d    [DEPTH];
   logic [DATA_W-1:0] ent_r2_q    [DEPTH], ent_r2_d    [DEPTH];
   logic [DATA_W-1:0] ent_imm_q   [DEPTH], ent_imm_d   [DEPTH];
   logic [ROB_W-1:0]  ent_rob_q   [DEPTH], ent_rob_d   [DEPTH];

   logic              snp_r1p [DEPTH], snp_r2p [DEPTH];
   logic [DATA_W-1:0] snp_r1v [DEPTH], snp_r2v [DEPTH];
   logic              dsp_r1p, dsp_r2p;
   logic [DATA_W-1:0] dsp_r1v, dsp_r2v;

   logic [DATA_W-1:0] h_addr;
   logic h_busy, h_io, h_rob_ok, mem_req_c, st_pop_c, ld_issue_c, ld_pop_c, pop_c, push_c;

   // Operand capture on the dispatch path and snooping for every stored entry
   lsb_cdb_match #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_dsp_r1 (
      .pend_i(bus.inst_r1_dep_v), .dep_i(bus.inst_r1_dep), .val_i(bus.inst_r1_val),
      .cdb_valid_i(bus.cdb_valid), .cdb_rob_id_i(bus.cdb_rob_id), .cdb_value_i(bus.cdb_value),
      .fi_i(fi_q), .fi_rob_i(fi_rob_q), .fi_val_i(fi_val_q), .pend_o(dsp_r1p), .val_o(dsp_r1v));
   lsb_cdb_match #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_dsp_r2 (
      .pend_i(bus.inst_r2_dep_v), .dep_i(bus.inst_r2_dep), .val_i(bus.inst_r2_val),
      .cdb_valid_i(bus.cdb_valid), .cdb_rob_id_i(bus.cdb_rob_id), .cdb_value_i(bus.cdb_value),
      .fi_i(fi_q), .fi_rob_i(fi_rob_q), .fi_val_i(fi_val_q), .pend_o(dsp_r2p), .val_o(dsp_r2v));

   for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
      lsb_cdb_match #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_r1 (
         .pend_i(ent_r1p_q[i]), .dep_i(ent_d1_q[i]), .val_i(ent_r1_q[i]),
         .cdb_valid_i(bus.cdb_valid), .cdb_rob_id_i(bus.cdb_rob_id), .cdb_value_i(bus.cdb_value),
         .fi_i(fi_q), .fi_rob_i(fi_rob_q), .fi_val_i(fi_val_q), .pend_o(snp_r1p[i]), .val_o(snp_r1v[i]));
      lsb_cdb_match #(.ROB_W(ROB_W), .CDB_N(CDB_N)) u_r2 (
         .pend_i(ent_r2p_q[i]), .dep_i(ent_d2_q[i]), .val_i(ent_r2_q[i]),
         .cdb_valid_i(bus.cdb_valid), .cdb_rob_id_i(bus.cdb_rob_id), .cdb_value_i(bus.cdb_value),
         .fi_i(fi_q), .fi_rob_i(fi_rob_q), .fi_val_i(fi_val_q), .pend_o(snp_r2p[i]), .val_o(snp_r2v[i]));
   end

   // Stores and I/O loads are non-speculative and wait for the ROB head
   assign h_addr     = ent_r1_q[head_q] + ent_imm_q[head_q];
   assign h_io       = (h_addr[IO_HI -: 2] == 2'b11);
   assign h_busy     = (count_q != '0) && ent_v_q[head_q];
   assign h_rob_ok   = !(ent_store_q[head_q] || h_io) || (bus.rob_head_id == ent_rob_q[head_q]);
   assign mem_req_c  = h_busy && (ent_st_q[head_q] == ST_WAIT) && !ent_r1p_q[head_q]
                       && !ent_r2p_q[head_q] && !drop_q && !bus.rob_clear && h_rob_ok;
   assign st_pop_c   = mem_req_c && bus.mem_handle && ent_store_q[head_q];
   assign ld_issue_c = mem_req_c && bus.mem_handle && !ent_store_q[head_q];
   assign ld_pop_c   = h_busy && (ent_st_q[head_q] == ST_ISSUED) && bus.mem_ready && !drop_q;
   assign pop_c      = st_pop_c || ld_pop_c;
   assign push_c     = bus.inst_valid && (count_q != CNT_W'(DEPTH)) && !bus.rob_clear;

   assign bus.lsb_full  = (count_q == CNT_W'(DEPTH))
                          || ((count_q == CNT_W'(DEPTH - 1)) && bus.inst_valid && !pop_c);
   assign bus.mem_req   = mem_req_c;
   assign bus.mem_write = ent_store_q[head_q];
   assign bus.mem_addr  = h_addr;
   assign bus.mem_wdata = ent_r2_q[head_q];
   assign bus.mem_type  = ent_f3_q[head_q];
   assign bus.lsb_fi     = fi_q;
   assign bus.lsb_rob_id = fi_rob_q;
   assign bus.lsb_value  = fi_val_q;

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      drop_d   = drop_q;
      fi_d     = fi_q;
      fi_rob_d = fi_rob_q;
      fi_val_d = fi_val_q;
      ent_v_d     = ent_v_q;
      ent_st_d    = ent_st_q;
      ent_store_d = ent_store_q;
      ent_f3_d    = ent_f3_q;
      ent_r1p_d   = ent_r1p_q;
      ent_r2p_d   = ent_r2p_q;
      ent_d1_d    = ent_d1_q;
      ent_d2_d    = ent_d2_q;
      ent_r1_d    = ent_r1_q;
      ent_r2_d    = ent_r2_q;
      ent_imm_d   = ent_imm_q;
      ent_rob_d   = ent_rob_q;
      if (rdy_in) begin
         fi_d = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_v_q[i]) begin
               ent_r1p_d[i] = snp_r1p[i];
               ent_r1_d[i]  = snp_r1v[i];
               ent_r2p_d[i] = snp_r2p[i];
               ent_r2_d[i]  = snp_r2v[i];
            end
         end
         if (pop_c) begin
            fi_d            = 1'b1;
            fi_rob_d        = ent_rob_q[head_q];
            fi_val_d        = st_pop_c ? '0 : bus.mem_rdata;
            ent_v_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
         end
         if (ld_issue_c) ent_st_d[head_q] = ST_ISSUED;
         if (push_c) begin
            ent_v_d[tail_q]     = 1'b1;
            ent_st_d[tail_q]    = ST_WAIT;
            ent_store_d[tail_q] = bus.inst_type[STORE_BIT];
            ent_f3_d[tail_q]    = bus.inst_type[2:0];
            ent_r1p_d[tail_q]   = dsp_r1p;
            ent_r1_d[tail_q]    = dsp_r1v;
            ent_d1_d[tail_q]    = bus.inst_r1_dep;
            ent_r2p_d[tail_q]   = dsp_r2p;
            ent_r2_d[tail_q]    = dsp_r2v;
            ent_d2_d[tail_q]    = bus.inst_r2_dep;
            ent_imm_d[tail_q]   = bus.inst_imm;
            ent_rob_d[tail_q]   = bus.inst_rob_id;
            tail_d              = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
         if (drop_q && bus.mem_ready) drop_d = 1'b0;
         // Flush: an issued head load still owes the cache one mem_ready to swallow
         if (bus.rob_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fi_d    = 1'b0;
            for (int i = 0; i < DEPTH; i++) ent_v_d[i] = 1'b0;
            if (h_busy && (ent_st_q[head_q] == ST_ISSUED) && !bus.mem_ready) drop_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
         fi_q     <= 1'b0;
         fi_rob_q <= '0;
         fi_val_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_v_q[i]     <= 1'b0;
            ent_st_q[i]    <= ST_WAIT;
            ent_store_q[i] <= 1'b0;
            ent_f3_q[i]    <= '0;
            ent_r1p_q[i]   <= 1'b0;
            ent_r2p_q[i]   <= 1'b0;
            ent_d1_q[i]    <= '0;
            ent_d2_q[i]    <= '0;
            ent_r1_q[i]    <= '0;
            ent_r2_q[i]    <= '0;
            ent_imm_q[i]   <= '0;
            ent_rob_q[i]   <= '0;
         end
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
         fi_q        <= fi_d;
         fi_rob_q    <= fi_rob_d;
         fi_val_q    <= fi_val_d;
         ent_v_q     <= ent_v_d;
         ent_st_q    <= ent_st_d;
         ent_store_q <= ent_store_d;
         ent_f3_q    <= ent_f3_d;
         ent_r1p_q   <= ent_r1p_d;
         ent_r2p_q   <= ent_r2p_d;
         ent_d1_q    <= ent_d1_d;
         ent_d2_q    <= ent_d2_d;
         ent_r1_q    <= ent_r1_d;
         ent_r2_q    <= ent_r2_d;
         ent_imm_q   <= ent_imm_d;
         ent_rob_q   <= ent_rob_d;
      end
   end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: issue, stores, CDB capture, full/wrap,
// flush with a stale load in flight, I/O ordering and async reset.
module tb_lsb_queue;
   import lsb_queue_pkg::*;

   logic clk_in = 1'b0;
   logic rst_n_in;
   logic rdy_in;
   int   n_chk  = 0;
   int   n_fail = 0;

   lsb_queue_if #(.ROB_W(4), .CDB_N(2)) bus ();

   lsb_queue #(.DEPTH(8), .ROB_W(4), .CDB_N(2), .IO_HI(17)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .bus(bus));

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_inst(input logic st, input logic [2:0] f3, input logic [31:0] r1,
                           input logic r1p, input logic [3:0] r1d, input logic [31:0] r2,
                           input logic [31:0] imm, input logic [3:0] rob);
      bus.inst_valid    = 1'b1;
      bus.inst_type     = {st, f3};
      bus.inst_r1_val   = r1;
      bus.inst_r1_dep_v = r1p;
      bus.inst_r1_dep   = r1d;
      bus.inst_r2_val   = r2;
      bus.inst_r2_dep_v = 1'b0;
      bus.inst_r2_dep   = 4'd0;
      bus.inst_imm      = imm;
      bus.inst_rob_id   = rob;
   endtask

   task automatic put(input logic st, input logic [2:0] f3, input logic [31:0] r1,
                      input logic r1p, input logic [3:0] r1d, input logic [31:0] r2,
                      input logic [31:0] imm, input logic [3:0] rob);
      set_inst(st, f3, r1, r1p, r1d, r2, imm, rob);
      cyc();
      bus.inst_valid = 1'b0;
   endtask

   int exp_rob  [7] = '{2, 3, 4, 5, 6, 7, 10};
   int exp_addr [7] = '{32'h1002, 32'h1003, 32'h1004, 32'h1005, 32'h1006, 32'h1007, 32'h2000};

   initial begin
      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      bus.rob_clear = 1'b0;  bus.rob_head_id = 4'd0;
      bus.inst_valid = 1'b0; bus.inst_type = 4'd0;
      bus.inst_r1_val = '0;  bus.inst_r2_val = '0;
      bus.inst_r1_dep_v = 1'b0; bus.inst_r2_dep_v = 1'b0;
      bus.inst_r1_dep = '0;  bus.inst_r2_dep = '0;
      bus.inst_imm = '0;     bus.inst_rob_id = '0;
      bus.cdb_valid = '0;    bus.cdb_rob_id = '0; bus.cdb_value = '0;
      bus.mem_handle = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;

      #3;
      chk("rst_fi", 32'(bus.lsb_fi), 0);
      chk("rst_rob", 32'(bus.lsb_rob_id), 0);
      chk("rst_val", bus.lsb_value, 0);
      chk("rst_req", 32'(bus.mem_req), 0);
      chk("rst_full", 32'(bus.lsb_full), 0);
      #4 rst_n_in = 1'b1;
      cyc();

      // rdy_in low: dispatch must not be accepted
      rdy_in = 1'b0;
      put(1'b0, F3_W, 32'h10, 1'b0, 4'd0, 0, 0, 4'd2);
      rdy_in = 1'b1;
      settle();
      chk("rdy_low_no_push", 32'(bus.mem_req), 0);

      // Plain load, handle at t, data at t+2, broadcast at t+3
      put(1'b0, F3_W, 32'h100, 1'b0, 4'd0, 0, 32'd4, 4'd1);
      settle();
      chk("ld_req", 32'(bus.mem_req), 1);
      chk("ld_addr", bus.mem_addr, 32'h104);
      chk("ld_write", 32'(bus.mem_write), 0);
      chk("ld_type", 32'(bus.mem_type), 32'(F3_W));
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      settle();
      chk("ld_issued_noreq", 32'(bus.mem_req), 0);
      cyc();
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD; cyc(); bus.mem_ready = 1'b0;
      chk("ld_fi", 32'(bus.lsb_fi), 1);
      chk("ld_val", bus.lsb_value, 32'hDEAD);
      chk("ld_rob", 32'(bus.lsb_rob_id), 1);
      cyc();
      chk("ld_fi_pulse", 32'(bus.lsb_fi), 0);

      // Store waits for ROB head
      bus.rob_head_id = 4'd2;
      put(1'b1, F3_W, 32'h200, 1'b0, 4'd0, 32'h55, 32'd8, 4'd3);
      settle();
      chk("st_not_head", 32'(bus.mem_req), 0);
      bus.rob_head_id = 4'd3;
      settle();
      chk("st_head_req", 32'(bus.mem_req), 1);
      chk("st_write", 32'(bus.mem_write), 1);
      chk("st_addr", bus.mem_addr, 32'h208);
      chk("st_wdata", bus.mem_wdata, 32'h55);
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      chk("st_fi", 32'(bus.lsb_fi), 1);
      chk("st_rob", 32'(bus.lsb_rob_id), 3);
      chk("st_val", bus.lsb_value, 0);
      settle();
      chk("st_empty", 32'(bus.mem_req), 0);

      // Same-cycle capture from CDB port 1
      set_inst(1'b0, F3_W, 32'h0, 1'b1, 4'd5, 0, 32'h10, 4'd4);
      bus.cdb_valid = 2'b10; bus.cdb_rob_id = 8'h50; bus.cdb_value = {32'h40, 32'h0};
      cyc();
      bus.inst_valid = 1'b0; bus.cdb_valid = '0;
      settle();
      chk("cap_req", 32'(bus.mem_req), 1);
      chk("cap_addr", bus.mem_addr, 32'h50);
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77; cyc(); bus.mem_ready = 1'b0;
      chk("cap_fi_rob", 32'(bus.lsb_rob_id), 4);

      // Stored entry snoop, lower CDB port has priority
      put(1'b0, F3_B, 32'h0, 1'b1, 4'd6, 0, 0, 4'd5);
      settle();
      chk("snp_wait", 32'(bus.mem_req), 0);
      bus.cdb_valid = 2'b11; bus.cdb_rob_id = 8'h66; bus.cdb_value = {32'h90, 32'h80};
      cyc();
      bus.cdb_valid = '0;
      settle();
      chk("snp_req", 32'(bus.mem_req), 1);
      chk("snp_prio_addr", bus.mem_addr, 32'h80);
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5; cyc(); bus.mem_ready = 1'b0;
      chk("snp_fi_rob", 32'(bus.lsb_rob_id), 5);

      // Fill to DEPTH with loads blocked on tag 15
      for (int i = 0; i < 8; i++) begin
         set_inst(1'b0, F3_W, 32'h0, 1'b1, 4'd15, 0, 32'(i), 4'(i));
         if (i == 7) begin
            settle();
            chk("full_last_push", 32'(bus.lsb_full), 1);
         end
         cyc();
      end
      bus.inst_valid = 1'b0;
      settle();
      chk("full_depth", 32'(bus.lsb_full), 1);
      put(1'b0, F3_W, 32'h3000, 1'b0, 4'd0, 0, 0, 4'd9);
      bus.cdb_valid = 2'b01; bus.cdb_rob_id = 8'h0F; bus.cdb_value = {32'h0, 32'h1000};
      cyc();
      bus.cdb_valid = '0;
      settle();
      chk("fill_head_addr", bus.mem_addr, 32'h1000);
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA0; cyc(); bus.mem_ready = 1'b0;
      chk("fill_pop0_rob", 32'(bus.lsb_rob_id), 0);
      settle();
      chk("fill_head1_addr", bus.mem_addr, 32'h1001);
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      // Push and pop together at DEPTH-1
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA1;
      set_inst(1'b0, F3_W, 32'h2000, 1'b0, 4'd0, 0, 0, 4'd10);
      settle();
      chk("pushpop_not_full", 32'(bus.lsb_full), 0);
      cyc();
      bus.inst_valid = 1'b0; bus.mem_ready = 1'b0;
      chk("pushpop_fi_rob", 32'(bus.lsb_rob_id), 1);
      settle();
      chk("cnt7_idle_full", 32'(bus.lsb_full), 0);
      bus.inst_valid = 1'b1;
      settle();
      chk("cnt7_push_full", 32'(bus.lsb_full), 1);
      bus.inst_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         settle();
         chk("drain_req", 32'(bus.mem_req), 1);
         chk("drain_addr", bus.mem_addr, 32'(exp_addr[i]));
         bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
         bus.mem_ready = 1'b1; bus.mem_rdata = 32'(exp_rob[i]); cyc(); bus.mem_ready = 1'b0;
         chk("drain_fi", 32'(bus.lsb_fi), 1);
         chk("drain_rob", 32'(bus.lsb_rob_id), 32'(exp_rob[i]));
      end
      settle();
      chk("drain_empty_req", 32'(bus.mem_req), 0);
      chk("drain_empty_full", 32'(bus.lsb_full), 0);

      // Flush with an issued load outstanding: stale data swallowed
      put(1'b0, F3_W, 32'h300, 1'b0, 4'd0, 0, 0, 4'd11);
      settle();
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      bus.rob_clear = 1'b1;
      settle();
      chk("clr_gates_req", 32'(bus.mem_req), 0);
      cyc();
      bus.rob_clear = 1'b0;
      chk("clr_no_fi", 32'(bus.lsb_fi), 0);
      put(1'b0, F3_W, 32'h400, 1'b0, 4'd0, 0, 0, 4'd12);
      settle();
      chk("drop_blocks_req", 32'(bus.mem_req), 0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD; cyc(); bus.mem_ready = 1'b0;
      chk("stale_not_bcast", 32'(bus.lsb_fi), 0);
      settle();
      chk("after_drop_req", 32'(bus.mem_req), 1);
      chk("after_drop_addr", bus.mem_addr, 32'h400);
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12; cyc(); bus.mem_ready = 1'b0;
      chk("new_ld_fi", 32'(bus.lsb_fi), 1);
      chk("new_ld_val", bus.lsb_value, 32'h12);
      chk("new_ld_rob", 32'(bus.lsb_rob_id), 12);

      // Flush coinciding with mem_ready: result suppressed, no drop
      put(1'b0, F3_W, 32'h500, 1'b0, 4'd0, 0, 0, 4'd13);
      settle();
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      bus.rob_clear = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
      cyc();
      bus.rob_clear = 1'b0; bus.mem_ready = 1'b0;
      chk("clr_ready_no_fi", 32'(bus.lsb_fi), 0);
      put(1'b0, F3_W, 32'h600, 1'b0, 4'd0, 0, 0, 4'd14);
      settle();
      chk("clr_ready_no_drop", 32'(bus.mem_req), 1);
      bus.rob_clear = 1'b1; cyc(); bus.rob_clear = 1'b0;
      settle();
      chk("clr_empty", 32'(bus.mem_req), 0);

      // I/O load held until ROB head, then async reset while issued
      bus.rob_head_id = 4'd3;
      put(1'b0, F3_W, 32'h30000, 1'b0, 4'd0, 0, 0, 4'd7);
      settle();
      chk("io_held", 32'(bus.mem_req), 0);
      bus.rob_head_id = 4'd7;
      settle();
      chk("io_head_req", 32'(bus.mem_req), 1);
      chk("io_addr", bus.mem_addr, 32'h30000);
      bus.mem_handle = 1'b1; cyc(); bus.mem_handle = 1'b0;
      #2 rst_n_in = 1'b0;
      #1;
      chk("arst_fi", 32'(bus.lsb_fi), 0);
      chk("arst_rob", 32'(bus.lsb_rob_id), 0);
      chk("arst_val", bus.lsb_value, 0);
      chk("arst_req", 32'(bus.mem_req), 0);
      chk("arst_addr", bus.mem_addr, 0);
      #2 rst_n_in = 1'b1;
      cyc();
      chk("post_rst_req", 32'(bus.mem_req), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
